// File: rtl/match_round_controller_pkg.sv
// Shared types for the fighter match sequencer: state and winner
// encodings, HP width and small scoring helpers.
package match_pkg;

    localparam int HP_W = 9;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_COUNTDOWN  = 3'd1,
        S_FIGHT      = 3'd2,
        S_ROUND_END  = 3'd3,
        S_MATCH_OVER = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2,
        WIN_DRAW = 2'd3
    } winner_t;

    function automatic winner_t hp_compare(
        input logic [HP_W-1:0] h1,
        input logic [HP_W-1:0] h2
    );
        if (h1 > h2)      return WIN_P1;
        else if (h2 > h1) return WIN_P2;
        else              return WIN_DRAW;
    endfunction

    function automatic logic [1:0] sat_inc(input logic [1:0] w);
        return (w == 2'd3) ? w : w + 2'd1;
    endfunction

endpackage

// File: rtl/match_round_controller_if.sv
// Game-side bundle of the match sequencer: HP in, match status out.
// master = controller, slave = HP/physics/status-bar side.
interface match_round_controller_if;
    import match_pkg::*;

    logic [HP_W-1:0] health_1;
    logic [HP_W-1:0] health_2;
    logic [2:0]      state;
    logic            controls_en;
    logic            round_rst;
    logic [1:0]      countdown;
    logic [6:0]      round_time;
    logic [2:0]      round_num;
    logic [1:0]      wins_1;
    logic [1:0]      wins_2;
    logic [1:0]      round_winner;
    logic [1:0]      match_winner;
    logic            paused;

    modport master (
        input  health_1, health_2,
        output state, controls_en, round_rst, countdown, round_time,
        output round_num, wins_1, wins_2, round_winner, match_winner,
        output paused
    );

    modport slave (
        output health_1, health_2,
        input  state, controls_en, round_rst, countdown, round_time,
        input  round_num, wins_1, wins_2, round_winner, match_winner,
        input  paused
    );

endinterface

// File: rtl/match_round_controller_second_strobe.sv
// game_tick synchroniser, rising-edge pulse and per-second divider.
// clr_i restarts the second; en_i low freezes the divider.
module second_strobe #(
    parameter int TICKS_PER_SEC = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic game_tick_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_p_o,
    output logic sec_p_o
);

    localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic          sync0_q, sync1_q, prev_q, tick_q;
    logic [CW-1:0] sub_cnt_q, sub_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q   <= 1'b0;
            sync1_q   <= 1'b0;
            prev_q    <= 1'b0;
            tick_q    <= 1'b0;
            sub_cnt_q <= '0;
        end else begin
            sync0_q   <= game_tick_i;
            sync1_q   <= sync0_q;
            prev_q    <= sync1_q;
            tick_q    <= sync1_q & ~prev_q;
            sub_cnt_q <= sub_cnt_d;
        end
    end

    assign tick_p_o = tick_q;
    assign sec_p_o  = tick_q & en_i & (sub_cnt_q == LAST);

    always_comb begin
        sub_cnt_d = sub_cnt_q;
        if (clr_i)
            sub_cnt_d = '0;
        else if (tick_q && en_i)
            sub_cnt_d = (sub_cnt_q == LAST) ? '0 : sub_cnt_q + CW'(1);
    end

endmodule

// File: rtl/match_round_controller.sv
// Two-player match sequencer: countdown, fight, round scoring, match result.
// Optional MATCH_PAUSE_EN adds pause_btn and the pause toggle in FIGHT.
module match_round_controller
    import match_pkg::*;
#(
    parameter int TICKS_PER_SEC     = 20,
    parameter int COUNTDOWN_SECONDS = 3,
    parameter int ROUND_SECONDS     = 60,
    parameter int END_HOLD_SECONDS  = 2,
    parameter int ROUNDS_TO_WIN     = 2,
    parameter int MAX_ROUNDS        = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic game_tick,
    input  logic start_btn,
`ifdef MATCH_PAUSE_EN
    input  logic pause_btn,
`endif
    match_round_controller_if.master bus
);

    localparam logic [1:0] CD_INIT   = 2'(COUNTDOWN_SECONDS);
    localparam logic [6:0] RT_INIT   = 7'(ROUND_SECONDS);
    localparam logic [2:0] HOLD_LAST = 3'(END_HOLD_SECONDS - 1);
    localparam logic [1:0] RTW       = 2'(ROUNDS_TO_WIN);
    localparam logic [2:0] MAXR      = 3'(MAX_ROUNDS);

    state_t     state_q, state_d;
    logic [1:0] countdown_q, countdown_d;
    logic [6:0] round_time_q, round_time_d;
    logic [2:0] round_num_q, round_num_d;
    logic [1:0] wins_1_q, wins_1_d, wins_2_q, wins_2_d;
    winner_t    rw_q, rw_d, mw_q, mw_d, res;
    logic [2:0] hold_q, hold_d;
    logic       paused_q, paused_d;
    logic       ctl_q, ctl_d, rrst_q, rrst_d;
    logic       start_prev_q, start_p, pause_p;
    logic       sec_p, tick_unused, ko, z1, z2;

    second_strobe #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_strobe (
        .clk         (clk),
        .rst_n       (reset),
        .game_tick_i (game_tick),
        .clr_i       (state_d != state_q),
        .en_i        (~paused_q),
        .tick_p_o    (tick_unused),
        .sec_p_o     (sec_p)
    );

    assign start_p = start_btn & ~start_prev_q;

`ifdef MATCH_PAUSE_EN
    logic pause_prev_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pause_prev_q <= 1'b0;
        else        pause_prev_q <= pause_btn;
    end
    assign pause_p = pause_btn & ~pause_prev_q;
`else
    assign pause_p = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            countdown_q  <= '0;
            round_time_q <= '0;
            round_num_q  <= '0;
            wins_1_q     <= '0;
            wins_2_q     <= '0;
            rw_q         <= WIN_NONE;
            mw_q         <= WIN_NONE;
            hold_q       <= '0;
            paused_q     <= 1'b0;
            ctl_q        <= 1'b0;
            rrst_q       <= 1'b1;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            countdown_q  <= countdown_d;
            round_time_q <= round_time_d;
            round_num_q  <= round_num_d;
            wins_1_q     <= wins_1_d;
            wins_2_q     <= wins_2_d;
            rw_q         <= rw_d;
            mw_q         <= mw_d;
            hold_q       <= hold_d;
            paused_q     <= paused_d;
            ctl_q        <= ctl_d;
            rrst_q       <= rrst_d;
            start_prev_q <= start_btn;
        end
    end

    assign z1 = (bus.health_1 == '0);
    assign z2 = (bus.health_2 == '0);
    assign ko = z1 | z2;

    always_comb begin
        state_d      = state_q;
        countdown_d  = countdown_q;
        round_time_d = round_time_q;
        round_num_d  = round_num_q;
        wins_1_d     = wins_1_q;
        wins_2_d     = wins_2_q;
        rw_d         = rw_q;
        mw_d         = mw_q;
        hold_d       = hold_q;
        paused_d     = paused_q;
        res          = WIN_NONE;
        unique case (state_q)
            S_IDLE: if (start_p) begin
                state_d     = S_COUNTDOWN;
                round_num_d = 3'd1;
                wins_1_d    = '0;
                wins_2_d    = '0;
                rw_d        = WIN_NONE;
                mw_d        = WIN_NONE;
                countdown_d = CD_INIT;
            end
            S_COUNTDOWN: if (sec_p) begin
                if (countdown_q == 2'd1) begin
                    state_d      = S_FIGHT;
                    round_time_d = RT_INIT;
                    countdown_d  = '0;
                end else begin
                    countdown_d = countdown_q - 2'd1;
                end
            end
            S_FIGHT: begin
                if (pause_p) paused_d = ~paused_q;
                // KO is checked first so it overrides a same-clk timeout
                if (ko) begin
                    state_d = S_ROUND_END;
                    unique case (1'b1)
                        (z1 & z2):  res = WIN_DRAW;
                        (z2 & ~z1): res = WIN_P1;
                        (z1 & ~z2): res = WIN_P2;
                        default:    res = WIN_NONE;
                    endcase
                end else if (sec_p) begin
                    round_time_d = round_time_q - 7'd1;
                    if (round_time_q == 7'd1) begin
                        state_d = S_ROUND_END;
                        res     = hp_compare(bus.health_1, bus.health_2);
                    end
                end
                if (state_d == S_ROUND_END) begin
                    rw_d     = res;
                    hold_d   = '0;
                    paused_d = 1'b0;
                    if (res == WIN_P1) wins_1_d = sat_inc(wins_1_q);
                    if (res == WIN_P2) wins_2_d = sat_inc(wins_2_q);
                end
            end
            S_ROUND_END: if (sec_p) begin
                if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 3'd1;
                end else if (wins_1_q == RTW || wins_2_q == RTW ||
                             round_num_q == MAXR) begin
                    state_d = S_MATCH_OVER;
                    if (wins_1_q > wins_2_q)      mw_d = WIN_P1;
                    else if (wins_2_q > wins_1_q) mw_d = WIN_P2;
                    else                          mw_d = WIN_DRAW;
                end else begin
                    state_d     = S_COUNTDOWN;
                    round_num_d = round_num_q + 3'd1;
                    countdown_d = CD_INIT;
                end
            end
            S_MATCH_OVER: if (start_p) begin
                state_d     = S_IDLE;
                round_num_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
        ctl_d  = (state_d == S_FIGHT) && !paused_d;
        rrst_d = (state_d == S_IDLE) || (state_d == S_COUNTDOWN);
    end

    assign bus.state        = state_q;
    assign bus.controls_en  = ctl_q;
    assign bus.round_rst    = rrst_q;
    assign bus.countdown    = countdown_q;
    assign bus.round_time   = round_time_q;
    assign bus.round_num    = round_num_q;
    assign bus.wins_1       = wins_1_q;
    assign bus.wins_2       = wins_2_q;
    assign bus.round_winner = rw_q;
    assign bus.match_winner = mw_q;
    assign bus.paused       = paused_q;

endmodule

// File: tb/tb_match_round_controller.sv
// Directed scoreboard bench for match_round_controller
// (TICKS_PER_SEC=2, ROUND_SECONDS=5; pause steps need MATCH_PAUSE_EN).
module tb_match_round_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic game_tick = 1'b0;
    logic start = 1'b0;
    logic pause = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc;

    typedef struct {
        string tag;
        int    val;
    } exp_t;
    exp_t sbq[$];

    match_round_controller_if mif ();

    match_round_controller #(
        .TICKS_PER_SEC (2),
        .ROUND_SECONDS (5)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .game_tick (game_tick),
        .start_btn (start),
`ifdef MATCH_PAUSE_EN
        .pause_btn (pause),
`endif
        .bus       (mif)
    );

    always #5 clk = ~clk;
    always #100 game_tick = ~game_tick;

    function automatic int get(string n);
        case (n)
            "state":        return int'(mif.state);
            "controls_en":  return int'(mif.controls_en);
            "round_rst":    return int'(mif.round_rst);
            "countdown":    return int'(mif.countdown);
            "round_time":   return int'(mif.round_time);
            "round_num":    return int'(mif.round_num);
            "wins_1":       return int'(mif.wins_1);
            "wins_2":       return int'(mif.wins_2);
            "round_winner": return int'(mif.round_winner);
            "match_winner": return int'(mif.match_winner);
            "paused":       return int'(mif.paused);
            default:        return -1;
        endcase
    endfunction

    task automatic chk(string tag, int obs, int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic push(string n, int v);
        exp_t e;
        e.tag = n;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk(e.tag, get(e.tag), e.val);
        end
    endtask

    task automatic wait_val(string n, int v, int budget, output int c);
        c = 0;
        push(n, v);
        while (get(n) != v && c < budget) begin
            @(negedge clk);
            c++;
        end
        drain();
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic set_hp(int a, int b);
        mif.health_1 = 9'(a);
        mif.health_2 = 9'(b);
    endtask

    initial begin
        set_hp(100, 100);
        // reset held: start must not leave IDLE
        repeat (3) @(negedge clk);
        pulse_start();
        push("state", 0);
        push("round_rst", 1);
        push("controls_en", 0);
        push("round_num", 0);
        push("countdown", 0);
        drain();

        @(negedge clk) rst_n = 1'b1;
        pulse_start();
        wait_val("state", 1, 5, cyc);
        push("countdown", 3);
        push("round_num", 1);
        push("round_rst", 1);
        push("controls_en", 0);
        drain();
        wait_val("countdown", 2, 60, cyc);
        wait_val("countdown", 1, 60, cyc);
        wait_val("state", 2, 60, cyc);
        push("round_time", 5);
        push("controls_en", 1);
        push("round_rst", 0);
        push("countdown", 0);
        drain();

        // round 1: P2 KO
        set_hp(100, 0);
        @(negedge clk);
        push("state", 3);
        push("round_winner", 1);
        push("wins_1", 1);
        push("controls_en", 0);
        push("round_rst", 0);
        drain();
        set_hp(100, 100);
        wait_val("state", 1, 120, cyc);
        push("round_num", 2);
        push("wins_1", 1);
        drain();

        // round 2: double KO
        wait_val("state", 2, 200, cyc);
        set_hp(0, 0);
        @(negedge clk);
        push("state", 3);
        push("round_winner", 3);
        push("wins_1", 1);
        push("wins_2", 0);
        drain();
        set_hp(100, 100);
        wait_val("state", 1, 120, cyc);
        push("round_num", 3);
        drain();

        // round 3: timeout, P2 ahead on HP
        wait_val("state", 2, 200, cyc);
        set_hp(50, 80);
        wait_val("state", 3, 250, cyc);
        chk("timeout_window", int'(cyc >= 175 && cyc <= 205), 1);
        push("round_winner", 2);
        push("wins_2", 1);
        push("round_time", 0);
        drain();
        set_hp(100, 100);
        wait_val("state", 1, 120, cyc);
        push("round_num", 4);
        drain();

        // round 4: KO lands on the timeout clk
        wait_val("state", 2, 200, cyc);
        set_hp(30, 80);
        wait_val("round_time", 1, 220, cyc);
        cyc = 0;
        while (!dut.sec_p && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk("sec_p_seen", int'(dut.sec_p), 1);
        set_hp(30, 0);
        @(negedge clk);
        push("state", 3);
        push("round_winner", 1);
        push("wins_1", 2);
        push("wins_2", 1);
        drain();
        set_hp(100, 100);
        wait_val("state", 4, 120, cyc);
        push("match_winner", 1);
        push("controls_en", 0);
        push("round_num", 4);
        drain();

        pulse_start();
        push("state", 0);
        push("round_num", 0);
        push("round_rst", 1);
        drain();
        pulse_start();
        push("state", 1);
        push("wins_1", 0);
        push("wins_2", 0);
        push("round_winner", 0);
        push("match_winner", 0);
        push("round_num", 1);
        drain();

        // start in COUNTDOWN is ignored
        pulse_start();
        repeat (2) @(negedge clk);
        push("state", 1);
        push("round_num", 1);
        drain();

        // async reset mid-fight
        wait_val("state", 2, 200, cyc);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        push("state", 0);
        push("controls_en", 0);
        push("round_rst", 1);
        push("round_num", 0);
        push("round_time", 0);
        drain();
        @(negedge clk) rst_n = 1'b1;

`ifdef MATCH_PAUSE_EN
        pulse_start();
        wait_val("state", 2, 200, cyc);
        wait_val("round_time", 4, 60, cyc);
        @(negedge clk) pause = 1'b1;
        @(negedge clk) pause = 1'b0;
        push("paused", 1);
        push("controls_en", 0);
        drain();
        repeat (120) @(negedge clk);
        push("round_time", 4);
        push("state", 2);
        drain();
        @(negedge clk) pause = 1'b1;
        @(negedge clk) pause = 1'b0;
        push("paused", 0);
        push("controls_en", 1);
        drain();
        wait_val("round_time", 3, 60, cyc);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
